// File: rtl/run_sequencer.sv
// Run sequencer: one program run of the 9-bit core, DataRAM port arbitration.
// Optional watchdog enabled by defining RUN_WATCHDOG_EN.
module run_sequencer #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          go,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_write,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          core_halt,
  input  logic          core_mem_rd,
  input  logic          core_mem_wr,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_init,
  output logic          core_run,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          to_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          wd_hit;
  logic          host_rd_acc;

`ifdef RUN_WATCHDOG_EN
  assign wd_hit = (cnt == CW'(MAX_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    host_ready = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        host_ready = host_valid;
        if (go && !host_valid) state_nx = INIT;
      end
      INIT: state_nx = RUN;
      RUN: begin
        if (core_halt || wd_hit) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign core_run    = (state == RUN);
  assign core_init   = (state == INIT);
  assign busy        = core_run || core_init;
  assign done        = (state == DONE);
  assign host_rd_acc = host_ready && !host_write;

  // Host traffic only reaches the RAM once it has been accepted.
  always_comb begin
    if (core_run) begin
      mem_rd     = core_mem_rd;
      mem_wr     = core_mem_wr;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      core_rdata = mem_rdata;
    end else begin
      mem_rd     = host_rd_acc;
      mem_wr     = host_ready && host_write;
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      core_rdata = '0;
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state    <= IDLE;
      cnt      <= '0;
      to_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nx;
      rvalid_q <= host_rd_acc;
      if (host_rd_acc) rdata_q <= mem_rdata;
      if (state == INIT) begin
        cnt  <= '0;
        to_q <= 1'b0;
      end else if (state == RUN) begin
        if (!(&cnt)) cnt <= cnt + 1'b1;
        if (wd_hit && !core_halt) to_q <= 1'b1;
      end
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign timeout     = to_q;
  assign cycle_count = cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: random host/core traffic vs a
// reference RAM and a run-length model.
module tb_run_sequencer;

  localparam int MAXC = 8;
  localparam int CWB  = 5;
  localparam int SAT  = 31;

  logic       CLK = 0;
  logic       start = 1;
  logic       go = 0;
  logic       host_valid = 0;
  logic       host_ready;
  logic       host_write = 0;
  logic [7:0] host_addr = 0;
  logic [7:0] host_wdata = 0;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       core_halt = 0;
  logic       core_mem_rd = 0;
  logic       core_mem_wr = 0;
  logic [7:0] core_addr = 0;
  logic [7:0] core_wdata = 0;
  logic [7:0] core_rdata;
  logic       core_init;
  logic       core_run;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [CWB-1:0] cycle_count;

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_wr) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  run_sequencer #(
    .AW(8), .DW(8), .CW(CWB), .MAX_CYCLES(MAXC)
  ) dut (
    .CLK(CLK), .start(start), .go(go),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_write(host_write), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .core_halt(core_halt),
    .core_mem_rd(core_mem_rd), .core_mem_wr(core_mem_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_init(core_init),
    .core_run(core_run), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_valid = 1; host_write = 1; host_addr = a; host_wdata = d;
    #1;
    chk("wr_ready", host_ready, 1);
    tick;
    host_valid = 0; host_write = 0;
    ref_mem[a] = d;
  endtask

  task automatic host_rd(input logic [7:0] a);
    host_valid = 1; host_write = 0; host_addr = a;
    tick;
    host_valid = 0;
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_data", host_rdata, ref_mem[a]);
    tick;
    chk("rd_rvalid_drop", host_rvalid, 0);
  endtask

  task automatic host_rd_burst(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      host_valid = 1; host_write = 0; host_addr = a;
      tick;
      chk("burst_rvalid", host_rvalid, 1);
      chk("burst_data", host_rdata, ref_mem[a]);
    end
    host_valid = 0;
    tick;
    chk("burst_end", host_rvalid, 0);
  endtask

  task automatic clear_core;
    core_mem_rd = 0; core_mem_wr = 0; core_halt = 0;
    host_valid = 0; host_write = 0;
  endtask

  // halt_at = 0 means the core never halts (watchdog builds only).
  task automatic run(input int halt_at, input bit dir);
    int n = 0;
    bit to = 0;
    int r;
    logic [7:0] a;
    logic [7:0] d;
    go = 1;
    tick;
    go = 1'($urandom_range(0, 1));
    core_halt = 1'($urandom_range(0, 1));
    chk("init_pulse", core_init, 1);
    chk("init_run", core_run, 0);
    chk("init_busy", busy, 1);
    tick;
    go = 0; core_halt = 0;
    for (int k = 1; k <= 64 && n == 0; k++) begin
      chk("run_on", core_run, 1);
      chk("run_init_low", core_init, 0);
      chk("run_cnt", cycle_count, sat(k - 1));
      go = 1'($urandom_range(0, 1));
      a = 8'($urandom); d = 8'($urandom);
      r = $urandom_range(0, 3);
      if (dir && k == 1) begin
        core_mem_wr = 1; core_addr = 8'h20; core_wdata = 8'h33;
        host_valid = 1; host_write = 1; host_addr = 8'h20;
        host_wdata = 8'h99;
        ref_mem[8'h20] = 8'h33;
        #1;
        chk("run_host_ready", host_ready, 0);
      end else if (dir && k == 2) begin
        host_valid = 1; host_write = 1; host_addr = 8'h21;
        host_wdata = ~ref_mem[8'h21];
        #1;
        chk("run_host_ready2", host_ready, 0);
      end else if (r == 1) begin
        core_mem_wr = 1; core_addr = a; core_wdata = d;
        ref_mem[a] = d;
      end else if (r == 2) begin
        core_mem_rd = 1; core_addr = a;
        #1;
        chk("core_rdata", core_rdata, ref_mem[a]);
      end else if (r == 3) begin
        host_valid = 1; host_write = 1; host_addr = a; host_wdata = d;
        #1;
        chk("run_host_blk", host_ready, 0);
      end
      core_halt = (k == halt_at);
`ifdef RUN_WATCHDOG_EN
      to = (k == MAXC) && (k != halt_at);
`endif
      tick;
      clear_core;
      go = 0;
      if (k == halt_at || to) n = k;
    end
    if (n == 0) chk("run_budget", 0, 1);
    chk("done_flag", done, 1);
    chk("done_run_off", core_run, 0);
    chk("done_busy", busy, 0);
    chk("done_cnt", cycle_count, sat(n));
    chk("done_timeout", timeout, to);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_run", core_run, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ready", host_ready, 0);
    host_valid = 1;
    #1;
    chk("rst_ready_follow", host_ready, 1);
    host_valid = 0;
    @(negedge CLK);
    start = 0;
    tick;

    for (int i = 0; i < 256; i++) host_wr(8'(i), 8'($urandom));
    host_wr(8'h10, 8'h5A);
    host_rd(8'h10);
    host_rd_burst(24);

    // core inputs ignored while idle
    core_halt = 1; core_mem_rd = 1; core_addr = 8'h10;
    #1;
    chk("idle_core_rdata", core_rdata, 0);
    tick;
    clear_core;
    chk("idle_halt_ign", busy | done, 0);

    run(5, 1'b1);
    host_rd(8'h20);
    host_rd(8'h21);

    // go with host_valid: host served, start deferred
    go = 1; host_valid = 1; host_write = 0; host_addr = 8'h10;
    #1;
    chk("go_hv_ready", host_ready, 1);
    tick;
    host_valid = 0;
    chk("go_hv_stay", busy, 0);
    chk("go_hv_rvalid", host_rvalid, 1);
    chk("go_hv_rdata", host_rdata, ref_mem[8'h10]);
    tick;
    go = 0;
    chk("go_late_init", core_init, 1);
    tick;
    core_halt = 1;
    tick;
    core_halt = 0;
    chk("short_done", done, 1);
    chk("short_cnt", cycle_count, 1);

    run(36, 1'b0);
    for (int i = 0; i < 6; i++) run($urandom_range(1, 40), 1'b0);
`ifdef RUN_WATCHDOG_EN
    run(0, 1'b0);
    run(MAXC, 1'b0);
`endif
    host_rd_burst(32);

    // asynchronous reset mid-run
    go = 1;
    tick;
    go = 0;
    tick; tick; tick;
    chk("pre_rst_run", core_run, 1);
    #2;
    start = 1;
    #1;
    chk("mid_rst_run", core_run, 0);
    chk("mid_rst_init", core_init, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", cycle_count, 0);
    chk("mid_rst_to", timeout, 0);
    chk("mid_rst_rvalid", host_rvalid, 0);
    tick;
    @(negedge CLK);
    start = 0;
    tick;
    host_rd(8'h20);
    host_rd_burst(32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
